// File: rtl/esaxi_tx_arbiter.sv
// rtl/esaxi_tx_arbiter.sv - two-source burst round-robin arbiter feeding one registered tx slot
module esaxi_tx_arbiter #(
   parameter int PW        = 104,
   parameter int MAX_BURST = 4
) (
   input  logic          s_axi_aclk,
   input  logic          s_axi_aresetn,
   input  logic          wr_access,
   input  logic [PW-1:0] wr_packet,
   output logic          wr_wait,
   input  logic          rd_access,
   input  logic [PW-1:0] rd_packet,
   output logic          rd_wait,
   output logic          tx_access,
   output logic [PW-1:0] tx_packet,
   input  logic          tx_wait,
   output logic [15:0]   stat_wr_cnt,
   output logic [15:0]   stat_rd_cnt
);

   typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN} state_t;
   typedef enum logic [1:0] {G_NONE, G_WR, G_RD} grant_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   state_t     state, state_nxt;
   grant_t     grant;
   logic [3:0] burst_cnt, burst_nxt;
   logic       last_rd, last_rd_nxt;
   logic       slot_free, wr_xfer, rd_xfer;

   assign slot_free = !tx_access || !tx_wait;

   always_comb begin
      grant       = G_NONE;
      state_nxt   = state;
      burst_nxt   = burst_cnt;
      last_rd_nxt = last_rd;
      wr_xfer     = 1'b0;
      rd_xfer     = 1'b0;

      // A saturated owner facing a waiting peer yields with a dead cycle (grant NONE).
      case (state)
         IDLE: begin
            if (wr_access && rd_access) grant = last_rd ? G_WR : G_RD;
            else if (wr_access)         grant = G_WR;
            else if (rd_access)         grant = G_RD;
         end
         WR_OWN:  grant = (wr_access && rd_access && burst_cnt == MAX_B) ? G_NONE : G_WR;
         RD_OWN:  grant = (rd_access && wr_access && burst_cnt == MAX_B) ? G_NONE : G_RD;
         default: grant = G_NONE;
      endcase

      wr_xfer = s_axi_aresetn && wr_access && (grant == G_WR) && slot_free;
      rd_xfer = s_axi_aresetn && rd_access && (grant == G_RD) && slot_free;

      case (state)
         IDLE: begin
            if (wr_xfer) begin
               state_nxt   = WR_OWN;
               burst_nxt   = 4'd1;
               last_rd_nxt = 1'b0;
            end else if (rd_xfer) begin
               state_nxt   = RD_OWN;
               burst_nxt   = 4'd1;
               last_rd_nxt = 1'b1;
            end
         end
         WR_OWN: begin
            if (!wr_access) begin
               state_nxt = IDLE;
            end else if (grant == G_NONE) begin
               state_nxt   = RD_OWN;
               burst_nxt   = 4'd0;
               last_rd_nxt = 1'b1;
            end else if (wr_xfer && burst_cnt != MAX_B) begin
               burst_nxt = burst_cnt + 4'd1;
            end
         end
         RD_OWN: begin
            if (!rd_access) begin
               state_nxt = IDLE;
            end else if (grant == G_NONE) begin
               state_nxt   = WR_OWN;
               burst_nxt   = 4'd0;
               last_rd_nxt = 1'b0;
            end else if (rd_xfer && burst_cnt != MAX_B) begin
               burst_nxt = burst_cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset gating keeps both sources stalled while the slot is forced empty.
   assign wr_wait = !(s_axi_aresetn && (grant == G_WR) && slot_free);
   assign rd_wait = !(s_axi_aresetn && (grant == G_RD) && slot_free);

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state     <= IDLE;
         burst_cnt <= 4'd0;
         last_rd   <= 1'b1;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_nxt;
         last_rd   <= last_rd_nxt;
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         tx_access   <= 1'b0;
         tx_packet   <= '0;
         stat_wr_cnt <= 16'd0;
         stat_rd_cnt <= 16'd0;
      end else begin
         if (wr_xfer) begin
            tx_access   <= 1'b1;
            tx_packet   <= wr_packet;
            stat_wr_cnt <= stat_wr_cnt + 16'd1;
         end else if (rd_xfer) begin
            tx_access   <= 1'b1;
            tx_packet   <= rd_packet;
            stat_rd_cnt <= stat_rd_cnt + 16'd1;
         end else if (slot_free) begin
            tx_access   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_esaxi_tx_arbiter.sv
// tb/tb_esaxi_tx_arbiter.sv - randomized and directed bench for esaxi_tx_arbiter
module tb_esaxi_tx_arbiter;
   localparam int PW        = 104;
   localparam int MAX_BURST = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_access = 1'b0, rd_access = 1'b0, tx_wait = 1'b0;
   logic [PW-1:0] wr_packet = '0, rd_packet = '0;
   logic          wr_wait, rd_wait, tx_access;
   logic [PW-1:0] tx_packet;
   logic [15:0]   stat_wr_cnt, stat_rd_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   esaxi_tx_arbiter #(.PW(PW), .MAX_BURST(MAX_BURST)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .wr_access(wr_access), .wr_packet(wr_packet), .wr_wait(wr_wait),
      .rd_access(rd_access), .rd_packet(rd_packet), .rd_wait(rd_wait),
      .tx_access(tx_access), .tx_packet(tx_packet), .tx_wait(tx_wait),
      .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [PW-1:0] rand_pkt(input logic is_wr);
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      r[PW-1] = is_wr;
      return r[PW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level reference: every accepted packet appears once, in order, one cycle later.
   logic [PW-1:0] exp_q[$];
   logic [PW-1:0] prev_pkt, prev_txp, m_pop;
   logic          prev_acc = 1'b0, prev_txa = 1'b0, prev_txw = 1'b0, m_aw, m_ar;
   logic [15:0]   m_wr = 16'd0, m_rd = 16'd0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_acc = 1'b0; prev_txa = 1'b0; prev_txw = 1'b0;
         m_wr = 16'd0; m_rd = 16'd0;
      end else begin
         m_aw = wr_access && !wr_wait;
         m_ar = rd_access && !rd_wait;
         n_checks++;
         if (m_aw && m_ar) begin n_fail++; $display("FAIL both_xfer: wr and rd accepted in one cycle"); end
         n_checks++;
         if (stat_wr_cnt !== m_wr) begin n_fail++; $display("FAIL stat_wr: got %0d want %0d", stat_wr_cnt, m_wr); end
         n_checks++;
         if (stat_rd_cnt !== m_rd) begin n_fail++; $display("FAIL stat_rd: got %0d want %0d", stat_rd_cnt, m_rd); end
         n_checks++;
         if (prev_acc) begin
            if (tx_access !== 1'b1 || tx_packet !== prev_pkt) begin
               n_fail++; $display("FAIL tx_latency: got %b/%h want 1/%h", tx_access, tx_packet, prev_pkt);
            end
         end else if (prev_txa && prev_txw) begin
            if (tx_access !== 1'b1 || tx_packet !== prev_txp) begin
               n_fail++; $display("FAIL tx_hold: got %b/%h want 1/%h", tx_access, tx_packet, prev_txp);
            end
         end else if (tx_access !== 1'b0) begin
            n_fail++; $display("FAIL tx_clear: tx_access got %b want 0", tx_access);
         end
         if (tx_access === 1'b1 && tx_wait === 1'b1) begin
            n_checks++;
            if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin
               n_fail++; $display("FAIL stall_waits: got %b%b want 11", wr_wait, rd_wait);
            end
         end
         if (tx_access === 1'b1 && tx_wait === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL tx_extra: got %h want none", tx_packet);
            end else begin
               m_pop = exp_q.pop_front();
               if (tx_packet !== m_pop) begin n_fail++; $display("FAIL tx_order: got %h want %h", tx_packet, m_pop); end
            end
         end
         if (m_aw) begin exp_q.push_back(wr_packet); m_wr = m_wr + 16'd1; end
         if (m_ar) begin exp_q.push_back(rd_packet); m_rd = m_rd + 16'd1; end
         prev_acc = m_aw || m_ar;
         prev_pkt = m_aw ? wr_packet : rd_packet;
         prev_txa = tx_access;
         prev_txw = tx_wait;
         prev_txp = tx_packet;
      end
   end

   task automatic go_idle(input int n);
      wr_access = 1'b0; rd_access = 1'b0; tx_wait = 1'b0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_access = 1'b1; rd_access = 1'b1; tx_wait = 1'b0;
      wr_packet = rand_pkt(1'b1); rd_packet = rand_pkt(1'b0);
      repeat (3) tick();
      n_checks++;
      if (tx_access !== 1'b0 || tx_packet !== '0) begin n_fail++; $display("FAIL reset_tx: got %b/%h want 0/0", tx_access, tx_packet); end
      n_checks++;
      if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin n_fail++; $display("FAIL reset_waits: got %b%b want 11", wr_wait, rd_wait); end
      n_checks++;
      if (stat_wr_cnt !== 16'd0 || stat_rd_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_wr_cnt, stat_rd_cnt); end
      wr_access = 1'b0; rd_access = 1'b0;
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_rd_only();
      logic [PW-1:0] p[3];
      for (int i = 0; i < 3; i++) p[i] = rand_pkt(1'b0);
      go_idle(2);
      for (int c = 0; c < 5; c++) begin
         rd_access = (c < 3);
         if (c < 3) rd_packet = p[c];
         @(negedge clk);
         n_checks++;
         if (wr_wait !== 1'b1) begin n_fail++; $display("FAIL rdonly_wr_wait: cycle %0d got %b want 1", c, wr_wait); end
         if (c < 3) begin
            n_checks++;
            if (rd_wait !== 1'b0) begin n_fail++; $display("FAIL rdonly_accept: cycle %0d rd_wait got %b want 0", c, rd_wait); end
         end
         if (c >= 1 && c <= 3) begin
            n_checks++;
            if (tx_access !== 1'b1 || tx_packet !== p[c-1]) begin
               n_fail++; $display("FAIL rdonly_tx: cycle %0d got %b/%h want 1/%h", c, tx_access, tx_packet, p[c-1]);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (tx_access !== 1'b0) begin n_fail++; $display("FAIL rdonly_end: tx_access got %b want 0", tx_access); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [PW-1:0] pw;
      logic [15:0]   sw, sr;
      go_idle(2);
      pw = rand_pkt(1'b1);
      wr_packet = pw; wr_access = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wr_wait !== 1'b0) begin n_fail++; $display("FAIL stall_first: wr_wait got %b want 0", wr_wait); end
      tick();
      tx_wait = 1'b1; wr_packet = rand_pkt(1'b1);
      rd_access = 1'b1; rd_packet = rand_pkt(1'b0);
      sw = m_wr; sr = m_rd;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (tx_access !== 1'b1 || tx_packet !== pw) begin n_fail++; $display("FAIL stall_hold: got %b/%h want 1/%h", tx_access, tx_packet, pw); end
         n_checks++;
         if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin n_fail++; $display("FAIL stall_waits_dir: got %b%b want 11", wr_wait, rd_wait); end
         n_checks++;
         if (stat_wr_cnt !== sw || stat_rd_cnt !== sr) begin n_fail++; $display("FAIL stall_stats: got %0d/%0d want %0d/%0d", stat_wr_cnt, stat_rd_cnt, sw, sr); end
         tick();
      end
      tx_wait = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_wait !== 1'b0 || rd_wait !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b%b want 01", wr_wait, rd_wait); end
      tick();
      go_idle(3);
   endtask

   task automatic test_bubble();
      logic aw, ar, seen_w;
      int   n_rd;
      go_idle(2);
      wr_access = 1'b1; wr_packet = rand_pkt(1'b1);
      @(negedge clk);
      n_checks++;
      if (wr_wait !== 1'b0) begin n_fail++; $display("FAIL bubble_w1: wr_wait got %b want 0", wr_wait); end
      tick();
      wr_packet = rand_pkt(1'b1); rd_access = 1'b1; rd_packet = rand_pkt(1'b0);
      @(negedge clk);
      n_checks++;
      if (wr_wait !== 1'b0 || rd_wait !== 1'b1) begin n_fail++; $display("FAIL bubble_w2: got %b%b want 01", wr_wait, rd_wait); end
      tick();
      wr_access = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rd_wait !== 1'b1) begin n_fail++; $display("FAIL bubble_gap: rd_wait got %b want 1", rd_wait); end
      tick();
      n_rd = 0; seen_w = 1'b0;
      for (int c = 0; c < 20 && !seen_w; c++) begin
         @(negedge clk);
         aw = wr_access && !wr_wait;
         ar = rd_access && !rd_wait;
         if (c == 0) begin
            n_checks++;
            if (ar !== 1'b1) begin n_fail++; $display("FAIL bubble_rd_grant: rd accepted got %b want 1", ar); end
         end
         if (ar) n_rd++;
         if (aw) seen_w = 1'b1;
         tick();
         wr_access = 1'b1;
         if (aw || c == 0) wr_packet = rand_pkt(1'b1);
         if (ar) rd_packet = rand_pkt(1'b0);
      end
      n_checks++;
      if (!seen_w || n_rd != MAX_BURST) begin n_fail++; $display("FAIL bubble_burst: rd burst got %0d want %0d (wr seen %b)", n_rd, MAX_BURST, seen_w); end
      go_idle(3);
   endtask

   task automatic test_random();
      logic aw = 1'b0, ar = 1'b0;
      int   pend_w = 0, pend_r = 0;
      for (int c = 0; c < 1500; c++) begin
         tx_wait = ($urandom_range(0, 3) == 0);
         if (!wr_access || aw) begin wr_access = ($urandom_range(0, 2) != 0); wr_packet = rand_pkt(1'b1); end
         if (!rd_access || ar) begin rd_access = ($urandom_range(0, 2) != 0); rd_packet = rand_pkt(1'b0); end
         @(negedge clk);
         aw = wr_access && !wr_wait;
         ar = rd_access && !rd_wait;
         if (rd_access && !ar) begin if (aw) pend_w++; end else pend_w = 0;
         if (wr_access && !aw) begin if (ar) pend_r++; end else pend_r = 0;
         if (aw || ar) begin
            n_checks++;
            if (pend_w > MAX_BURST || pend_r > MAX_BURST) begin
               n_fail++; $display("FAIL rand_fair: run wr %0d rd %0d limit %0d", pend_w, pend_r, MAX_BURST);
            end
         end
         tick();
      end
      go_idle(4);
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d packets outstanding want 0", exp_q.size()); end
   endtask

   task automatic test_round_robin();
      logic aw, ar, exp_w;
      int   n_acc = 0;
      rst_n = 1'b0; go_idle(2); rst_n = 1'b1; tick();
      wr_access = 1'b1; wr_packet = rand_pkt(1'b1);
      rd_access = 1'b1; rd_packet = rand_pkt(1'b0);
      for (int c = 0; c < 20000 && n_acc < 8192; c++) begin
         @(negedge clk);
         aw = wr_access && !wr_wait;
         ar = rd_access && !rd_wait;
         if (aw || ar) begin
            exp_w = ((n_acc / MAX_BURST) % 2) == 0;
            n_checks++;
            if (aw !== exp_w) begin n_fail++; $display("FAIL rr_order: packet %0d wr got %b want %b", n_acc, aw, exp_w); end
            n_acc++;
         end
         tick();
         if (aw) wr_packet = rand_pkt(1'b1);
         if (ar) rd_packet = rand_pkt(1'b0);
         if (n_acc == 8192) begin wr_access = 1'b0; rd_access = 1'b0; end
      end
      n_checks++;
      if (n_acc != 8192) begin n_fail++; $display("FAIL rr_timeout: accepted %0d want 8192", n_acc); end
      go_idle(3);
      n_checks++;
      if (stat_wr_cnt !== 16'd4096 || stat_rd_cnt !== 16'd4096) begin
         n_fail++; $display("FAIL rr_stats: got %0d/%0d want 4096/4096", stat_wr_cnt, stat_rd_cnt);
      end
   endtask

   task automatic test_wrap();
      logic aw;
      int   n_wr = 4096;
      wr_access = 1'b1; wr_packet = rand_pkt(1'b1); rd_access = 1'b0; tx_wait = 1'b0;
      for (int c = 0; c < 70000 && n_wr < 65535; c++) begin
         @(negedge clk);
         aw = wr_access && !wr_wait;
         if (aw) n_wr++;
         tick();
         if (aw) wr_packet = rand_pkt(1'b1);
         if (n_wr == 65535) wr_access = 1'b0;
      end
      go_idle(3);
      n_checks++;
      if (stat_wr_cnt !== 16'hFFFF || stat_rd_cnt !== 16'd4096) begin
         n_fail++; $display("FAIL wrap_pre: got %h/%0d want ffff/4096", stat_wr_cnt, stat_rd_cnt);
      end
      wr_access = 1'b1; wr_packet = rand_pkt(1'b1);
      @(negedge clk);
      n_checks++;
      if (wr_wait !== 1'b0) begin n_fail++; $display("FAIL wrap_accept: wr_wait got %b want 0", wr_wait); end
      tick();
      wr_access = 1'b0;
      tick();
      n_checks++;
      if (stat_wr_cnt !== 16'h0000 || stat_rd_cnt !== 16'd4096) begin
         n_fail++; $display("FAIL wrap_post: got %h/%0d want 0000/4096", stat_wr_cnt, stat_rd_cnt);
      end
      go_idle(2);
   endtask

   task automatic test_reset_midburst();
      logic [PW-1:0] pw;
      logic          found = 1'b0;
      wr_access = 1'b1; wr_packet = rand_pkt(1'b1);
      rd_access = 1'b1; rd_packet = rand_pkt(1'b0);
      tick(); tick();
      for (int c = 0; c < 10 && tx_access !== 1'b1; c++) tick();
      n_checks++;
      if (tx_access !== 1'b1) begin n_fail++; $display("FAIL mid_setup: tx_access got %b want 1", tx_access); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx_access !== 1'b0 || tx_packet !== '0) begin n_fail++; $display("FAIL mid_async: got %b/%h want 0/0", tx_access, tx_packet); end
      n_checks++;
      if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin n_fail++; $display("FAIL mid_waits: got %b%b want 11", wr_wait, rd_wait); end
      tick(); tick();
      pw = rand_pkt(1'b1);
      wr_packet = pw; rd_packet = rand_pkt(1'b0);
      rst_n = 1'b1;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (tx_access === 1'b1) begin
            found = 1'b1;
            n_checks++;
            if (tx_packet !== pw) begin n_fail++; $display("FAIL mid_first: got %h want %h", tx_packet, pw); end
         end
         tick();
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL mid_timeout: no tx packet after release"); end
      go_idle(3);
   endtask

   initial begin
      test_reset();
      test_rd_only();
      test_stall();
      test_bubble();
      test_random();
      test_round_robin();
      test_wrap();
      test_reset_midburst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/esaxi_tx_arbiter.md
ESAXI_TX_ARBITER -- requirements
Module: esaxi_tx_arbiter

Interface
REQ-001 Parameter PW, default 104, SHALL set the width of every packet port in bits.
REQ-002 Parameter MAX_BURST, default 4, range 1-15, SHALL set the maximum number of consecutive packets granted to one source while the other source is requesting.
REQ-003 Port s_axi_aclk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port s_axi_aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 Port wr_access, input, 1: write-packet source valid.
REQ-006 Port wr_packet, input, PW: write packet; stable while wr_access && wr_wait.
REQ-007 Port wr_wait, output, 1: backpressure to the write source.
REQ-008 Port rd_access, input, 1: read-request source valid.
REQ-009 Port rd_packet, input, PW: read-request packet.
REQ-010 Port rd_wait, output, 1: backpressure to the read source.
REQ-011 Port tx_access, output, 1: registered output valid.
REQ-012 Port tx_packet, output, PW: registered output packet.
REQ-013 Port tx_wait, input, 1: downstream backpressure.
REQ-014 Port stat_wr_cnt, output, 16: count of accepted write packets.
REQ-015 Port stat_rd_cnt, output, 16: count of accepted read packets.

Function
REQ-016 The output slot SHALL be free when !tx_access || !tx_wait.
REQ-017 Source X SHALL transfer in a cycle iff X_access && grant==X && slot free; X_wait SHALL equal !(grant==X && slot free), combinational.
REQ-018 A transfer in cycle N SHALL load tx_packet and set tx_access in cycle N+1 (one-cycle latency).
REQ-019 With tx_access && tx_wait, tx_access and tx_packet SHALL hold unchanged.
REQ-020 With slot free and no transfer, tx_access SHALL clear at the next edge.
REQ-021 State machine SHALL have states IDLE, WR_OWN, RD_OWN; grant is NONE/WR/RD.
REQ-022 IDLE: one requester -> grant to it; both -> grant to the source other than last_grant; none -> grant NONE.
REQ-023 A transfer from IDLE SHALL move to X_OWN with burst_cnt=1 and last_grant=X.
REQ-024 X_OWN: grant SHALL be X; each X transfer increments burst_cnt, saturating at MAX_BURST.
REQ-025 X_OWN with X_access low SHALL return to IDLE at the next edge (one bubble cycle, no grant to the other source that cycle).
REQ-026 X_OWN with burst_cnt==MAX_BURST and the other source's access high SHALL move to the other source's OWN state with burst_cnt=0, last_grant updated, with no X transfer that cycle.
REQ-027 X_OWN with burst_cnt==MAX_BURST and the other source idle SHALL keep grant X, burst_cnt held.
REQ-028 Ownership changes SHALL NOT occur while a source is stalled only by tx_wait; burst_cnt counts transfers, not cycles.
REQ-029 stat_wr_cnt/stat_rd_cnt SHALL increment by 1 per accepted packet, wrapping 0xFFFF->0x0000.
REQ-030 No packet SHALL be dropped or duplicated outside reset.

Reset
REQ-031 s_axi_aresetn low SHALL immediately force tx_access=0, tx_packet=0, state=IDLE, burst_cnt=0, last_grant=RD, both stat counters=0.
REQ-032 During reset wr_wait and rd_wait SHALL be 1.
REQ-033 A packet held on tx when reset asserts SHALL be discarded; no packet SHALL appear on tx before the first transfer following reset release.
REQ-034 Reset release SHALL be synchronised by the integrator; the first grant SHALL go to WR if both sources request.

Verification
REQ-035 Both sources request continuously, tx_wait=0, MAX_BURST=4 -> tx sequence W,W,W,W,R,R,R,R,W...; stat counts equal after 8k packets.
REQ-036 Only rd_access with 3 packets, tx_wait=0 -> 3 packets on tx on consecutive cycles, each one cycle after acceptance; wr_wait=1 throughout.
REQ-037 tx_wait held 1 for 5 cycles with a packet on tx -> tx_packet unchanged, both waits=1, stat counts unchanged; one transfer the cycle tx_wait drops.
REQ-038 WR_OWN, wr_access drops after 2 packets with rd_access high -> one bubble cycle, then RD granted; burst_cnt restarts at 1.
REQ-039 stat_wr_cnt preset via 65535 write transfers, one more write -> stat_wr_cnt=0x0000, stat_rd_cnt unaffected.
REQ-040 Reset asserted mid-burst with tx_access=1 -> tx_access=0 without a clock edge; after release with both requesting, first tx packet is the write packet.
